// File: rtl/tpu_pkg.sv
// Shared TPU types: byte/row types and the weight
// receiver FSM state encoding.
package tpu_pkg;
  localparam int BYTE_WIDTH = 8;
  localparam int DEFAULT_MATRIX_WIDTH = 14;

  typedef logic [BYTE_WIDTH-1:0] byte_type;
  typedef byte_type [DEFAULT_MATRIX_WIDTH-1:0] weight_row_type;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } weight_rx_state_type;
endpackage

// File: rtl/weight_shadow_bank.sv
// Shadow tile storage: row data, signed bits, valid mask
// and a registered count of distinct rows loaded.
module weight_shadow_bank
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH  = DEFAULT_MATRIX_WIDTH,
  parameter int ADDR_WIDTH    = $clog2(MATRIX_WIDTH),
  parameter int ROW_CTR_WIDTH = $clog2(MATRIX_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     wr_en,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic                     wr_signed,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] wr_data,
  input  logic                     clear,
  output logic [MATRIX_WIDTH*MATRIX_WIDTH*BYTE_WIDTH-1:0] rows,
  output logic [MATRIX_WIDTH-1:0]  row_signed,
  output logic [ROW_CTR_WIDTH-1:0] rows_loaded,
  output logic                     full
);
  localparam int ROW_BITS = MATRIX_WIDTH * BYTE_WIDTH;

  byte_type [MATRIX_WIDTH-1:0] mem [MATRIX_WIDTH];
  logic [MATRIX_WIDTH-1:0] row_valid;
  logic [MATRIX_WIDTH-1:0] valid_nxt;
  logic [ROW_CTR_WIDTH-1:0] cnt_nxt;

  // A clear and a write on the same edge leave only the new row valid.
  always_comb begin
    valid_nxt = clear ? '0 : row_valid;
    cnt_nxt   = clear ? '0 : rows_loaded;
    if (wr_en && !valid_nxt[wr_addr]) begin
      valid_nxt[wr_addr] = 1'b1;
      cnt_nxt = cnt_nxt + ROW_CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < MATRIX_WIDTH; r++) mem[r] <= '0;
      row_signed  <= '0;
      row_valid   <= '0;
      rows_loaded <= '0;
      full        <= 1'b0;
    end else if (enable) begin
      if (wr_en) begin
        mem[wr_addr]        <= wr_data;
        row_signed[wr_addr] <= wr_signed;
      end
      row_valid   <= valid_nxt;
      rows_loaded <= cnt_nxt;
      full        <= (cnt_nxt == ROW_CTR_WIDTH'(MATRIX_WIDTH));
    end
  end

  for (genvar r = 0; r < MATRIX_WIDTH; r++) begin : g_rows
    assign rows[r*ROW_BITS +: ROW_BITS] = mem[r];
  end
endmodule

// File: rtl/weight_load_receiver.sv
// Collects a weight tile into the shadow bank and swaps
// it atomically into the active bank on request.
module weight_load_receiver
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH  = DEFAULT_MATRIX_WIDTH,
  parameter int ROW_CTR_WIDTH = $clog2(MATRIX_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     load_weight,
  input  logic [BYTE_WIDTH-1:0]    weight_addr,
  input  logic                     is_weight_signed,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] weight_data,
  input  logic                     activate,
  output logic [MATRIX_WIDTH*MATRIX_WIDTH*BYTE_WIDTH-1:0] active_weights,
  output logic [MATRIX_WIDTH-1:0]  active_signed,
  output logic [ROW_CTR_WIDTH-1:0] rows_loaded,
  output logic                     shadow_full,
  output logic                     swap_done,
  output logic                     addr_error,
  output logic                     busy
);
  localparam int ADDR_WIDTH = $clog2(MATRIX_WIDTH);
  localparam int TILE_BITS  = MATRIX_WIDTH * MATRIX_WIDTH * BYTE_WIDTH;

  weight_rx_state_type state;
  weight_rx_state_type state_nxt;

  logic addr_ok;
  logic wr_en;
  logic xfer;
  logic err_q;
  logic [TILE_BITS-1:0] shadow;
  logic [MATRIX_WIDTH-1:0] shadow_signed;

  assign addr_ok = weight_addr < BYTE_WIDTH'(MATRIX_WIDTH);
  assign wr_en   = load_weight & addr_ok;

  weight_shadow_bank #(
    .MATRIX_WIDTH (MATRIX_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ROW_CTR_WIDTH(ROW_CTR_WIDTH)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (weight_addr[ADDR_WIDTH-1:0]),
    .wr_signed  (is_weight_signed),
    .wr_data    (weight_data),
    .clear      (xfer),
    .rows       (shadow),
    .row_signed (shadow_signed),
    .rows_loaded(rows_loaded),
    .full       (shadow_full)
  );

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    unique case (state)
      FILL: begin
        if (activate) begin
          if (shadow_full) begin
            state_nxt = SWAP;
            xfer      = 1'b1;
          end else begin
            state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        if (shadow_full) begin
          state_nxt = SWAP;
          xfer      = 1'b1;
        end
      end
      SWAP:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // The error flag is a one-shot pulse, so it tracks every edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= FILL;
      active_weights <= '0;
      active_signed  <= '0;
      err_q          <= 1'b0;
    end else begin
      err_q <= enable & load_weight & ~addr_ok;
      if (enable) begin
        state <= state_nxt;
        if (xfer) begin
          active_weights <= shadow;
          active_signed  <= shadow_signed;
        end
      end
    end
  end

  assign swap_done  = enable & (state == SWAP);
  assign addr_error = enable & err_q;
  assign busy       = (state != FILL);
endmodule

// File: tb/tb_weight_load_receiver.sv
// Directed plus randomized bench for weight_load_receiver
// against a tile-level reference model.
module tb_weight_load_receiver;
  localparam int MW = 14;
  localparam int BW = 8;
  localparam int RB = MW * BW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic load_weight = 1'b0;
  logic [7:0] weight_addr = '0;
  logic is_weight_signed = 1'b0;
  logic [RB-1:0] weight_data = '0;
  logic activate = 1'b0;
  logic [MW*RB-1:0] active_weights;
  logic [MW-1:0] active_signed;
  logic [3:0] rows_loaded;
  logic shadow_full;
  logic swap_done;
  logic addr_error;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_swaps = 0;
  bit chk_on = 0;

  weight_load_receiver dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .load_weight     (load_weight),
    .weight_addr     (weight_addr),
    .is_weight_signed(is_weight_signed),
    .weight_data     (weight_data),
    .activate        (activate),
    .active_weights  (active_weights),
    .active_signed   (active_signed),
    .rows_loaded     (rows_loaded),
    .shadow_full     (shadow_full),
    .swap_done       (swap_done),
    .addr_error      (addr_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Reference model: tiles as byte matrices, mode 0 idle,
  // 1 waiting for a full tile, 2 cycle right after a swap.
  logic [7:0] m_sh [MW][MW];
  logic [7:0] m_act [MW][MW];
  bit m_shs [MW];
  bit m_acts [MW];
  bit m_val [MW];
  int m_cnt = 0;
  int m_mode = 0;
  bit m_err = 0;

  always @(posedge clk) begin : model
    bit xf;
    if (!rst) begin
      for (int r = 0; r < MW; r++) begin
        for (int c = 0; c < MW; c++) begin
          m_sh[r][c] = 8'h00;
          m_act[r][c] = 8'h00;
        end
        m_shs[r] = 0;
        m_acts[r] = 0;
        m_val[r] = 0;
      end
      m_cnt = 0;
      m_mode = 0;
      m_err = 0;
    end else begin
      m_err = enable && load_weight && (int'(weight_addr) >= MW);
      if (enable) begin
        xf = (m_cnt == MW) && ((m_mode == 0 && activate) || m_mode == 1);
        if (xf) begin
          m_act = m_sh;
          m_acts = m_shs;
          for (int r = 0; r < MW; r++) m_val[r] = 0;
          m_cnt = 0;
        end
        if (load_weight && int'(weight_addr) < MW) begin
          for (int c = 0; c < MW; c++)
            m_sh[weight_addr][c] = weight_data[c*8 +: 8];
          m_shs[weight_addr] = is_weight_signed;
          if (!m_val[weight_addr]) begin
            m_val[weight_addr] = 1;
            m_cnt++;
          end
        end
        if (xf) m_mode = 2;
        else if (m_mode == 2) m_mode = 0;
        else if (m_mode == 0 && activate) m_mode = 1;
      end
    end
  end

  always @(negedge clk) if (chk_on) begin : cmp
    logic [RB-1:0] er;
    logic [MW-1:0] es;
    bit bad;
    bad = 0;
    n_cmp++;
    for (int r = 0; r < MW; r++) begin
      for (int c = 0; c < MW; c++) er[c*8 +: 8] = m_act[r][c];
      es[r] = m_acts[r];
      if (active_weights[r*RB +: RB] !== er) begin
        bad = 1;
        $display("FAIL active_row%0d got %h want %h",
                 r, active_weights[r*RB +: RB], er);
      end
    end
    if (active_signed !== es) begin
      bad = 1;
      $display("FAIL active_signed got %h want %h", active_signed, es);
    end
    if (rows_loaded !== 4'(m_cnt)) begin
      bad = 1;
      $display("FAIL rows_loaded got %0d want %0d", rows_loaded, m_cnt);
    end
    if (shadow_full !== (m_cnt == MW)) begin
      bad = 1;
      $display("FAIL shadow_full got %b want %b", shadow_full, m_cnt == MW);
    end
    if (swap_done !== (m_mode == 2 && enable)) begin
      bad = 1;
      $display("FAIL swap_done got %b want %b", swap_done,
               m_mode == 2 && enable);
    end
    if (addr_error !== (m_err && enable)) begin
      bad = 1;
      $display("FAIL addr_error got %b want %b", addr_error, m_err && enable);
    end
    if (busy !== (m_mode != 0)) begin
      bad = 1;
      $display("FAIL busy got %b want %b", busy, m_mode != 0);
    end
    if (bad) n_bad++;
  end

  always @(negedge clk) if (swap_done === 1'b1) n_swaps++;

  task automatic lit(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic cyc(bit en, bit ld, int a, bit sg, logic [RB-1:0] d, bit act);
    enable = en;
    load_weight = ld;
    weight_addr = 8'(a);
    is_weight_signed = sg;
    weight_data = d;
    activate = act;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, '0, 0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [RB-1:0] row_pat(int r);
    logic [RB-1:0] v;
    for (int c = 0; c < MW; c++) v[c*8 +: 8] = 8'(r * 16 + c);
    return v;
  endfunction

  function automatic logic [RB-1:0] fill_b(logic [7:0] b);
    logic [RB-1:0] v;
    for (int c = 0; c < MW; c++) v[c*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [7:0] abyte(int r, int c);
    return active_weights[(r*MW + c)*8 +: 8];
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    chk_on = 1;
    idle();
    at_neg();
    lit("reset_rows_loaded", 32'(rows_loaded), 0);
    lit("reset_active_zero", 32'(active_weights == '0), 1);
    rst = 1'b1;

    for (int r = 0; r < MW; r++) cyc(1, 1, r, r[0], row_pat(r), 0);
    at_neg();
    lit("fill_rows_loaded", 32'(rows_loaded), 14);
    lit("fill_shadow_full", 32'(shadow_full), 1);
    lit("fill_active_zero", 32'(active_weights == '0), 1);

    cyc(1, 0, 0, 0, '0, 1);
    at_neg();
    lit("swap_pulse", 32'(swap_done), 1);
    lit("swap_row2_col5", 32'(abyte(2, 5)), 32'h25);
    lit("swap_row13_col13", 32'(abyte(13, 13)), 32'hdd);
    lit("swap_signed", 32'(active_signed), 32'h2aaa);
    idle();
    at_neg();
    lit("post_swap_busy", 32'(busy), 0);
    lit("post_swap_rows", 32'(rows_loaded), 0);
    lit("swap_count_1", 32'(n_swaps), 1);

    cyc(1, 1, 3, 0, fill_b(8'hAA), 0);
    cyc(1, 1, 3, 1, fill_b(8'h55), 0);
    at_neg();
    lit("rewrite_rows", 32'(rows_loaded), 1);
    for (int r = 0; r < 5; r++) if (r != 3) cyc(1, 1, r, 0, row_pat(r), 0);
    cyc(1, 0, 0, 0, '0, 1);
    at_neg();
    lit("pending_busy", 32'(busy), 1);
    for (int r = 5; r < MW; r++) cyc(1, 1, r, 0, row_pat(r), r == 8);
    idle();
    idle();
    idle();
    at_neg();
    lit("pending_swap_count", 32'(n_swaps), 2);
    lit("row3_col0", 32'(abyte(3, 0)), 32'h55);
    lit("row3_col13", 32'(abyte(3, 13)), 32'h55);

    cyc(1, 1, 14, 0, fill_b(8'h77), 0);
    at_neg();
    lit("oor_addr_error", 32'(addr_error), 1);
    lit("oor_rows", 32'(rows_loaded), 0);
    idle();
    at_neg();
    lit("oor_pulse_end", 32'(addr_error), 0);
    cyc(0, 1, 2, 0, fill_b(8'h11), 0);
    cyc(0, 1, 14, 0, fill_b(8'h11), 1);
    at_neg();
    lit("disabled_rows", 32'(rows_loaded), 0);
    lit("disabled_err", 32'(addr_error), 0);
    lit("disabled_busy", 32'(busy), 0);

    for (int r = 0; r < MW; r++) cyc(1, 1, r, 0, fill_b(8'(8'h10 + r)), 0);
    cyc(1, 1, 0, 1, fill_b(8'hEE), 1);
    at_neg();
    lit("xfer_load_rows", 32'(rows_loaded), 1);
    lit("xfer_old_row0", 32'(abyte(0, 0)), 32'h10);
    lit("xfer_row13", 32'(abyte(13, 4)), 32'h1d);
    idle();
    cyc(1, 0, 0, 0, '0, 1);
    at_neg();
    lit("pre_reset_busy", 32'(busy), 1);
    rst = 1'b0;
    idle();
    at_neg();
    lit("mid_reset_busy", 32'(busy), 0);
    lit("mid_reset_rows", 32'(rows_loaded), 0);
    lit("mid_reset_active", 32'(active_weights == '0), 1);
    rst = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      logic [RB-1:0] d;
      for (int c = 0; c < MW; c++) d[c*8 +: 8] = 8'($urandom);
      rst = ($urandom_range(0, 399) != 0);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15), 1'($urandom), d,
          $urandom_range(0, 19) == 0);
    end
    rst = 1'b1;
    idle();
    idle();
    at_neg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
